// File: rtl/alu_pkg.sv
// Shared definitions for the 1-bit ALU slice: mode encodings and the
// result triple carried from each functional unit to the output register.
package alu_pkg;

  localparam logic [1:0] MODE_ADD   = 2'b00;
  localparam logic [1:0] MODE_SUB   = 2'b01;
  localparam logic [1:0] MODE_CMP   = 2'b10;
  localparam logic [1:0] MODE_LOGIC = 2'b11;

  // f is the main result, cout the carry or secondary result, n the
  // "A less than B" flag that only the comparator ever drives high.
  typedef struct packed {
    logic f;
    logic cout;
    logic n;
  } result_t;

endpackage

// File: rtl/alu_1_bit_units.sv
// Leaf building blocks of the ALU slice: half/full adders, the 1-bit
// magnitude comparator, the mode decoder and the enable gate that stands
// in for a tristate buffer so that no Z or X can reach the outputs.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// Two half adders in series; the carries can never both be 1, so an OR
// merges them into the full-adder carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s1;
  logic c1;
  logic c2;

  half_adder ha_lo (.a(a),  .b(b),   .s(s1),  .c(c1));
  half_adder ha_hi (.a(s1), .b(cin), .s(sum), .c(c2));

  assign cout = c1 | c2;
endmodule

// Exactly one of eq/gt/lt is high for any pair of bits.
module comparator_1_bit (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic gt,
  output logic lt
);
  assign eq = ~(a ^ b);
  assign gt = a & ~b;
  assign lt = ~a & b;
endmodule

// One-hot unit enables: bit 0 ADD, bit 1 SUB, bit 2 CMP, bit 3 LOGIC.
module decoder_2to4
  import alu_pkg::*;
(
  input  logic [1:0] sel,
  output logic [3:0] en
);
  // Decode the mode into exactly one active enable.
  always_comb begin
    en = 4'b0000;
    case (sel)
      MODE_ADD:   en = 4'b0001;
      MODE_SUB:   en = 4'b0010;
      MODE_CMP:   en = 4'b0100;
      MODE_LOGIC: en = 4'b1000;
      default:    en = 4'b0000;
    endcase
  end
endmodule

// A disabled unit drives zeros, so the gated results can simply be ORed
// together where a real bus would have resolved tristate drivers.
module tristate
  import alu_pkg::*;
(
  input  logic    en,
  input  result_t d,
  output result_t q
);
  assign q = en ? d : '0;
endmodule

// File: rtl/alu_1_bit.sv
// 1-bit ALU slice: four functional units, a mode decoder selecting one of
// them, an enable-gated merge, and a registered output with synchronous
// reset. Carry chaining between slices is handled by the parent ALU.
module alu_1_bit
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic Cin,
  input  logic M0,
  input  logic M1,
  output logic F,
  output logic Cout,
  output logic N
);

  logic [3:0] unit_en;
  logic       add_sum;
  logic       add_cout;
  logic       sub_sum;
  logic       sub_cout;
  logic       b_inv;
  logic       cmp_eq;
  logic       cmp_gt;
  logic       cmp_lt;

  result_t add_res;
  result_t sub_res;
  result_t cmp_res;
  result_t logic_res;
  result_t add_gated;
  result_t sub_gated;
  result_t cmp_gated;
  result_t logic_gated;
  result_t merged;
  result_t out_q;

  decoder_2to4 u_dec (.sel({M1, M0}), .en(unit_en));

  full_adder u_add (.a(A), .b(B), .cin(Cin), .sum(add_sum), .cout(add_cout));

  // Subtraction is A + ~B + Cin; a carry-out of 1 means no borrow.
  assign b_inv = ~B;
  full_adder u_sub (.a(A), .b(b_inv), .cin(Cin), .sum(sub_sum), .cout(sub_cout));

  comparator_1_bit u_cmp (.a(A), .b(B), .eq(cmp_eq), .gt(cmp_gt), .lt(cmp_lt));

  assign add_res   = '{f: add_sum, cout: add_cout, n: 1'b0};
  assign sub_res   = '{f: sub_sum, cout: sub_cout, n: 1'b0};
  assign cmp_res   = '{f: cmp_eq,  cout: cmp_gt,   n: cmp_lt};
  assign logic_res = '{f: A & B,   cout: A | B,    n: 1'b0};

  tristate u_gate_add   (.en(unit_en[0]), .d(add_res),   .q(add_gated));
  tristate u_gate_sub   (.en(unit_en[1]), .d(sub_res),   .q(sub_gated));
  tristate u_gate_cmp   (.en(unit_en[2]), .d(cmp_res),   .q(cmp_gated));
  tristate u_gate_logic (.en(unit_en[3]), .d(logic_res), .q(logic_gated));

  assign merged = add_gated | sub_gated | cmp_gated | logic_gated;

  // Capture the selected unit's result; reset overrides any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= merged;
    end
  end

  assign F    = out_q.f;
  assign Cout = out_q.cout;
  assign N    = out_q.n;

endmodule

// File: tb/tb_alu_1_bit.sv
// Self-checking bench for alu_1_bit: directed cases with literal
// expectations, then randomized traffic compared every cycle against an
// arithmetic reference model.
module tb_alu_1_bit;

  logic clk;
  logic rst;
  logic A;
  logic B;
  logic Cin;
  logic M0;
  logic M1;
  logic F;
  logic Cout;
  logic N;

  int total;
  int bad;
  logic armed;
  logic [2:0] exp_q;

  alu_1_bit dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
    .M0(M0), .M1(M1), .F(F), .Cout(Cout), .N(N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {F, Cout, N} from the plain arithmetic meaning
  // of each mode.
  function automatic logic [2:0] model(input logic [1:0] mode, input logic a,
                                       input logic b, input logic cin);
    int s;
    logic [2:0] r;
    r = 3'b000;
    case (mode)
      2'd0: begin
        s = int'(a) + int'(b) + int'(cin);
        r = {s[0], s[1], 1'b0};
      end
      2'd1: begin
        s = int'(a) + (1 - int'(b)) + int'(cin);
        r = {s[0], s[1], 1'b0};
      end
      2'd2: r = {(a == b), (int'(a) > int'(b)), (int'(a) < int'(b))};
      default: r = {a & b, a | b, 1'b0};
    endcase
    return r;
  endfunction

  // Every-cycle comparison against the model, starting once reset is seen.
  initial begin
    armed = 1'b0;
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        exp_q = 3'b000;
        armed = 1'b1;
      end else begin
        exp_q = model({M1, M0}, A, B, Cin);
      end
      @(negedge clk);
      if (armed) begin
        total++;
        if ($isunknown({F, Cout, N}) || ({F, Cout, N} !== exp_q)) begin
          bad++;
          $display("[TB] FAIL model_cmp t=%0t got F/Cout/N=%b%b%b want %b",
                   $time, F, Cout, N, exp_q);
        end
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic a, input logic b,
                               input logic cin, input logic [1:0] mode);
    rst = r;
    A   = a;
    B   = b;
    Cin = cin;
    {M1, M0} = mode;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic ef,
                             input logic ec, input logic en);
    total++;
    if ($isunknown({F, Cout, N}) || ({F, Cout, N} !== {ef, ec, en})) begin
      bad++;
      $display("[TB] FAIL %s got F/Cout/N=%b%b%b want %b%b%b",
               name, F, Cout, N, ef, ec, en);
    end
  endtask

  initial begin
    logic [1:0] sw_modes [4];
    logic [2:0] sw_exp [4];
    int s;
    total = 0;
    bad   = 0;
    rst = 1'b0; A = 1'b0; B = 1'b0; Cin = 1'b0; M0 = 1'b0; M1 = 1'b0;
    @(negedge clk);

    // Reset overrides inputs; the next edge captures normally.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
    checkOutput("reset", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    checkOutput("post_reset", 1'b1, 1'b1, 1'b0);

    // ADD sweep over all operand combinations.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      applyStimulus(1'b0, v[2], v[1], v[0], 2'b00);
      s = int'(v[2]) + int'(v[1]) + int'(v[0]);
      checkOutput($sformatf("add_%b", v), s[0], s[1], 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    checkOutput("add_011", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("add_100", 1'b1, 1'b0, 1'b0);

    // SUB.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    checkOutput("sub_101", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
    checkOutput("sub_011", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
    checkOutput("sub_111", 1'b0, 1'b1, 1'b0);

    // CMP with Cin toggling.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b10);
    checkOutput("cmp_eq", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
    checkOutput("cmp_gt", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
    checkOutput("cmp_lt", 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    checkOutput("cmp_lt_cin", 1'b0, 1'b0, 1'b1);

    // LOGIC.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
    checkOutput("logic_10", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b11);
    checkOutput("logic_11", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    checkOutput("logic_00", 1'b0, 1'b0, 1'b0);

    // Mode switch every cycle with A=0, B=1, Cin=1.
    sw_modes[0] = 2'b00; sw_exp[0] = 3'b010;
    sw_modes[1] = 2'b10; sw_exp[1] = 3'b001;
    sw_modes[2] = 2'b01; sw_exp[2] = 3'b100;
    sw_modes[3] = 2'b11; sw_exp[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] e;
      e = sw_exp[i];
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, sw_modes[i]);
      checkOutput($sformatf("switch_%b", sw_modes[i]), e[2], e[1], e[0]);
    end

    // Reset asserted together with a mode change.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
    checkOutput("reset_mode_change", 1'b0, 1'b0, 1'b0);

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                    1'($urandom), 1'($urandom), 1'($urandom),
                    2'($urandom_range(0, 3)));
    end

    rst = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
